// File: rtl/maq_h_if.sv
// ============================================================================
// maq_h_if : control inputs and hour-display outputs of the hours stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface maq_h_if;
  logic       maqh_enable;
  logic       maqh_incremento;
  logic       maqh_ajuste;
  logic       maqh_modo12;
  logic [3:0] maqh_lsd;
  logic [1:0] maqh_msd;
  logic       maqh_pm;
  logic       maqh_incrementadia;

  modport master (
    output maqh_enable,
    output maqh_incremento,
    output maqh_ajuste,
    output maqh_modo12,
    input  maqh_lsd,
    input  maqh_msd,
    input  maqh_pm,
    input  maqh_incrementadia
  );

  modport slave (
    input  maqh_enable,
    input  maqh_incremento,
    input  maqh_ajuste,
    input  maqh_modo12,
    output maqh_lsd,
    output maqh_msd,
    output maqh_pm,
    output maqh_incrementadia
  );
endinterface

`default_nettype wire

// File: rtl/maq_h.sv
// ============================================================================
// maq_h : hours stage, BCD 00..23 count with 24 h / 12 h AM-PM display
// Rev 1.0
// ============================================================================
`default_nettype none

module maq_h #(
  parameter int INICIO_HORA = 0
) (
  input  wire logic maqh_clock,
  input  wire logic maqh_reset,
  maq_h_if.slave    bus
);

  localparam logic [1:0] C_INIT_MSD = 2'(INICIO_HORA / 10);
  localparam logic [3:0] C_INIT_LSD = 4'(INICIO_HORA % 10);

  logic       aj_prev_q, aj_prev_d;
  logic [1:0] cnt_msd_q, cnt_msd_d;
  logic [3:0] cnt_lsd_q, cnt_lsd_d;
  logic [1:0] disp_msd_q, disp_msd_d;
  logic [3:0] disp_lsd_q, disp_lsd_d;
  logic       pm_q, pm_d;
  logic       dia_q, dia_d;

  logic       w_aj_ev;
  logic       w_car_ev;
  logic       w_step;
  logic [4:0] w_hour_bin;
  logic [4:0] w_h12;

  assign w_aj_ev  = bus.maqh_ajuste & ~aj_prev_q;
  assign w_car_ev = bus.maqh_enable & bus.maqh_incremento;
  assign w_step   = w_car_ev | w_aj_ev;

  // Count step; a simultaneous carry and adjust collapse into one step
  always_comb begin
    aj_prev_d = bus.maqh_ajuste;
    cnt_msd_d = cnt_msd_q;
    cnt_lsd_d = cnt_lsd_q;
    dia_d     = 1'b0;
    if (w_step) begin
      if ((cnt_msd_q == 2'd2) && (cnt_lsd_q == 4'd3)) begin
        cnt_msd_d = 2'd0;
        cnt_lsd_d = 4'd0;
        dia_d     = w_car_ev;
      end else if (cnt_lsd_q == 4'd9) begin
        cnt_lsd_d = 4'd0;
        cnt_msd_d = cnt_msd_q + 2'd1;
      end else begin
        cnt_lsd_d = cnt_lsd_q + 4'd1;
      end
    end
  end

  // Display follows the next-state count so both change on the same edge
  always_comb begin
    w_hour_bin = (5'(cnt_msd_d) * 5'd10) + 5'(cnt_lsd_d);
    w_h12      = 5'd12;
    disp_msd_d = cnt_msd_d;
    disp_lsd_d = cnt_lsd_d;
    pm_d       = 1'b0;
    if (bus.maqh_modo12) begin
      if (w_hour_bin == 5'd0) begin
        w_h12 = 5'd12;
        pm_d  = 1'b0;
      end else if (w_hour_bin < 5'd12) begin
        w_h12 = w_hour_bin;
        pm_d  = 1'b0;
      end else if (w_hour_bin == 5'd12) begin
        w_h12 = 5'd12;
        pm_d  = 1'b1;
      end else begin
        w_h12 = w_hour_bin - 5'd12;
        pm_d  = 1'b1;
      end
      if (w_h12 >= 5'd10) begin
        disp_msd_d = 2'd1;
        disp_lsd_d = 4'(w_h12 - 5'd10);
      end else begin
        disp_msd_d = 2'd0;
        disp_lsd_d = w_h12[3:0];
      end
    end
  end

  always_ff @(posedge maqh_clock or negedge maqh_reset) begin
    if (!maqh_reset) begin
      aj_prev_q  <= 1'b0;
      cnt_msd_q  <= C_INIT_MSD;
      cnt_lsd_q  <= C_INIT_LSD;
      disp_msd_q <= C_INIT_MSD;
      disp_lsd_q <= C_INIT_LSD;
      pm_q       <= 1'b0;
      dia_q      <= 1'b0;
    end else begin
      aj_prev_q  <= aj_prev_d;
      cnt_msd_q  <= cnt_msd_d;
      cnt_lsd_q  <= cnt_lsd_d;
      disp_msd_q <= disp_msd_d;
      disp_lsd_q <= disp_lsd_d;
      pm_q       <= pm_d;
      dia_q      <= dia_d;
    end
  end

  assign bus.maqh_lsd           = disp_lsd_q;
  assign bus.maqh_msd           = disp_msd_q;
  assign bus.maqh_pm            = pm_q;
  assign bus.maqh_incrementadia = dia_q;

endmodule

`default_nettype wire

// File: doc/maq_h.md
Name: maq_h

Overview:
- Hours stage of the clock. Consumes the one-cycle carry pulse from the minutes stage and keeps a 24-hour BCD hour count (00..23).
- Accepts a manual hour-adjust button.
- Drives the hour display digits in 24 h or 12 h format with an AM/PM flag.
- Emits a one-cycle day-carry pulse on a natural 23→00 rollover.

Parameters:
- INICIO_HORA, 0, hour value (binary 0..23) loaded on reset; values >23 are illegal.

Ports:
- maqh_clock  input  1  system clock, all state on rising edge
- maqh_reset  input  1  asynchronous, active-low reset
- maqh_enable  input  1  gates the minutes carry (clock running)
- maqh_incremento  input  1  one-cycle carry pulse from the minutes stage
- maqh_ajuste  input  1  manual adjust level (debounced button, high = pressed)
- maqh_modo12  input  1  1 = 12 h display, 0 = 24 h display
- maqh_lsd  output  4  displayed hour units digit, BCD
- maqh_msd  output  2  displayed hour tens digit, BCD
- maqh_pm  output  1  1 = PM (12 h mode only)
- maqh_incrementadia  output  1  one-cycle day-carry pulse

Behaviour:
- Reset (maqh_reset=0, asynchronous):
  - internal count = INICIO_HORA.
  - maqh_lsd/maqh_msd = 24 h BCD of INICIO_HORA.
  - maqh_pm=0, maqh_incrementadia=0, adjust edge register = 0.
- First rising edge after reset release:
  - outputs re-evaluated against maqh_modo12.
  - an ajuste already high at release counts as a rising edge.
- Adjust pulse:
  - aj_ev = maqh_ajuste & ~aj_prev, where aj_prev is maqh_ajuste registered every cycle.
  - Holding the button gives exactly one step.
- Carry event: car_ev = maqh_enable & maqh_incremento.
- Adjust is honoured regardless of maqh_enable, so hours can be set while the clock is stopped.
- Step = car_ev | aj_ev. Simultaneous car_ev and aj_ev give a single +1 step, not two.
- Step arithmetic on the internal BCD count (cnt_msd 2 b, cnt_lsd 4 b):
  - cnt=23 → 00
  - cnt_lsd=9 → cnt_lsd=0, cnt_msd+1
  - otherwise cnt_lsd+1
  - Internal count never leaves 00..23.
- maqh_incrementadia:
  - 1 for exactly the cycle after the edge where a step wraps 23→00 and car_ev=1.
  - Wrap caused by adjust alone does not pulse.
  - 0 in all other cycles, including with enable low.
- Display is registered and loaded every edge from the next-state count and the current maqh_modo12.
  - Latency: count change and display change land on the same edge; a modo12 change shows on the next edge.
  - 24 h mode: digits = count, maqh_pm=0.
  - 12 h mode mapping:
    - 00 → 12, pm=0
    - 01..11 → same digits, pm=0
    - 12 → 12, pm=1
    - 13..23 → count−12, pm=1
  - 12 h digits are BCD with msd 0 or 1.
- Asynchronous reset mid-operation: immediate return to reset values, a pending step is lost, no day pulse.
- No state machine beyond the count. The step and display logic must be fully specified for every count in 00..23; there are no default-to-X paths.

Test Plan:
- INICIO_HORA=0, reset released, modo12=0 → lsd=0, msd=0, pm=0, incrementadia=0. Ten carry pulses with enable=1 → displays 10 (msd=1, lsd=0).
- Count 09, one carry → 10. Count 19, one carry → 20. Carry pulse with enable=0 → count unchanged, no day pulse.
- Count 23, enable=1, one carry → display 00 on that edge, incrementadia=1 for exactly one cycle. Same wrap via ajuste rising edge → 00 with incrementadia=0.
- Hold ajuste high 20 cycles with enable=0 → exactly +1. Carry and ajuste rising edge in the same cycle at count 05 → 06, not 07.
- modo12=1, step through all 24 hours →
  - 00→12/pm0
  - 11→11/pm0
  - 12→12/pm1
  - 13→01/pm1
  - 23→11/pm1
  - Toggle modo12 at count 15 → 03/pm1, then on the next edge 15/pm0.
- INICIO_HORA=23, count at 07, reset asserted asynchronously mid-cycle → outputs immediately 23/pm0, incrementadia=0. After release with modo12=1 → 11/pm1 on the first edge.
